// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// requesters; the winner is registered and presented to the register file a cycle later.
module regfile_write_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     freeze,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        writeRegister,
  output logic [DATA_W-1:0]        writeData,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_p0;
  logic              vld_p0;
  logic [PTR_W-1:0]  gnt_idx_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic              conflict_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  // Stage p0: combinational arbitration, search starts at rr_ptr_q and wraps
  always_comb begin
    gnt_p0     = '0;
    vld_p0     = 1'b0;
    gnt_idx_p0 = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!vld_p0 && !freeze && req_valid[idx]) begin
        vld_p0      = 1'b1;
        gnt_p0[idx] = 1'b1;
        gnt_idx_p0  = PTR_W'(idx);
      end
    end
  end

  assign addr_p0     = req_addr[gnt_idx_p0*ADDR_W +: ADDR_W];
  assign data_p0     = req_data[gnt_idx_p0*DATA_W +: DATA_W];
  assign conflict_p0 = ($countones(req_valid) >= 2);
  assign req_ready   = rst ? '0 : gnt_p0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (vld_p0) begin
      rr_ptr_d = (gnt_idx_p0 == PTR_W'(NREQ - 1)) ? '0 : gnt_idx_p0 + 1'b1;
    end
    cnt_d = conflict_p0 ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stage p1: registered write; address/data hold when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0 && (addr_p0 != '0);
      if (vld_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign regWrite      = vld_p1;
  assign writeRegister = addr_p1;
  assign writeData     = data_p1;
  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference arbiter model predicts
// grants per cycle and queues the expected register-file write for the next cycle.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        freeze;
  logic [2:0]  req_ready, req_ready4;
  logic        regWrite, regWrite4;
  logic [4:0]  writeRegister, writeRegister4;
  logic [31:0] writeData, writeData4;
  logic [15:0] conflict_cnt;
  logic [3:0]  conflict_cnt4;

  regfile_write_arbiter #(.NREQ(3), .DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .freeze(freeze), .regWrite(regWrite),
    .writeRegister(writeRegister), .writeData(writeData), .conflict_cnt(conflict_cnt));

  regfile_write_arbiter #(.NREQ(3), .DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready4), .freeze(freeze), .regWrite(regWrite4),
    .writeRegister(writeRegister4), .writeData(writeData4), .conflict_cnt(conflict_cnt4));

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  always @(posedge clk) if (regWrite) rf[writeRegister] <= writeData;

  typedef struct packed {logic we; logic [4:0] a; logic [31:0] d;} exp_t;
  exp_t sbq[$];

  int          checks = 0;
  int          failures = 0;
  int          m_ptr;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt4;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  obs_ready;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_grant();
    logic [2:0] g;
    g = '0;
    if (!freeze) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr + k) % 3;
        if (g == '0 && req_valid[idx]) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  // One clock: check grant at negedge, queue expectation, check write after posedge
  task automatic cycle(input string tag);
    logic [2:0] g;
    exp_t       e;
    @(negedge clk);
    g = model_grant();
    obs_ready = req_ready;
    check_val({tag, ":ready"}, req_ready, g);
    check_val({tag, ":ready4"}, req_ready4, g);
    check_val({tag, ":cnt"}, conflict_cnt, m_cnt);
    check_val({tag, ":cnt4"}, conflict_cnt4, m_cnt4);
    e.we = 1'b0; e.a = m_addr; e.d = m_data;
    for (int i = 0; i < 3; i++) begin
      if (g[i]) begin
        e.a   = req_addr[i*5 +: 5];
        e.d   = req_data[i*32 +: 32];
        e.we  = (e.a != 5'd0);
        m_ptr = (i + 1) % 3;
      end
    end
    m_addr = e.a;
    m_data = e.d;
    if ($countones(req_valid) >= 2) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1'b1;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_val({tag, ":sbq"}, sbq.size(), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check_val({tag, ":regWrite"}, regWrite, e.we);
      check_val({tag, ":writeRegister"}, writeRegister, e.a);
      check_val({tag, ":writeData"}, writeData, e.d);
    end
  endtask

  // Assert rst asynchronously, check cleared state before any edge, release after a posedge
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_val({tag, ":rst_regWrite"}, regWrite, 1'b0);
    check_val({tag, ":rst_cnt"}, conflict_cnt, 16'd0);
    check_val({tag, ":rst_ready"}, req_ready, 3'b000);
    check_val({tag, ":rst_wreg"}, {writeRegister, writeData}, 37'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_ptr  = 0;
    m_cnt  = '0;
    m_cnt4 = '0;
    m_addr = '0;
    m_data = '0;
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0;
    req_valid = 3'b111; req_addr = '0; req_data = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    #2;
    do_reset("init");
    req_valid = 3'b000;

    // Single request
    req_valid = 3'b001; set_req(0, 5'd5, 32'hDEADBEEF);
    cycle("t1");
    check_val("t1_grant", obs_ready, 3'b001);
    check_val("t1_rw", {regWrite, writeRegister, writeData}, {1'b1, 5'd5, 32'hDEADBEEF});
    req_valid = 3'b000;
    cycle("t1_idle");
    check_val("t1_rf5", rf[5], 32'hDEADBEEF);

    // Register 0 write from requester 1 (rr_ptr=1)
    req_valid = 3'b010; set_req(1, 5'd0, 32'h1234);
    cycle("t3");
    check_val("t3_grant", obs_ready, 3'b010);
    check_val("t3_regWrite", regWrite, 1'b0);
    req_valid = 3'b101; set_req(0, 5'd3, 32'hA0); set_req(2, 5'd4, 32'hA2);
    cycle("t3_ptr");
    check_val("t3_ptr_is_2", obs_ready, 3'b100);

    // Freeze with 011 pending, rr_ptr=0
    req_valid = 3'b011; freeze = 1'b1;
    set_req(0, 5'd8, 32'h80); set_req(1, 5'd9, 32'h90);
    for (int i = 0; i < 3; i++) begin
      cycle("t4_frz");
      check_val("t4_frz_ready", obs_ready, 3'b000);
    end
    check_val("t4_frz_rw", regWrite, 1'b0);
    freeze = 1'b0;
    cycle("t4_resume");
    check_val("t4_resume_grant", obs_ready, 3'b001);
    req_valid = 3'b000;
    cycle("t4_idle");

    // All three valid for 6 cycles from a clean state
    do_reset("t2rst");
    req_valid = 3'b111;
    set_req(0, 5'd10, 32'h100); set_req(1, 5'd11, 32'h111); set_req(2, 5'd12, 32'h122);
    for (int i = 0; i < 6; i++) begin
      cycle("t2");
      check_val("t2_order", obs_ready, 3'b001 << (i % 3));
    end
    check_val("t2_cnt6", conflict_cnt, 16'd6);

    // Same destination from two requesters: later grant wins
    req_valid = 3'b011; set_req(0, 5'd7, 32'hAAAA0000); set_req(1, 5'd7, 32'hBBBB1111);
    cycle("same0");
    req_valid = 3'b010;
    cycle("same1");
    req_valid = 3'b000;
    cycle("same_idle");
    check_val("same_rf7", rf[7], 32'hBBBB1111);

    // Randomised traffic; requests stay stable until accepted
    req_valid = '0;
    for (int n = 0; n < 80; n++) begin
      freeze = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || obs_ready[i]) begin
          req_valid[i] = $urandom_range(0, 2) != 0;
          set_req(i, 5'($urandom_range(0, 31)), $urandom);
        end
      end
      cycle("rand");
    end
    freeze = 1'b0;

    // Async reset while a write is registered
    req_valid = 3'b001; set_req(0, 5'd6, 32'h66);
    cycle("t5_pre");
    check_val("t5_pre_rw", regWrite, 1'b1);
    #2;
    req_valid = 3'b110;
    set_req(1, 5'd13, 32'h13); set_req(2, 5'd14, 32'h14);
    do_reset("t5");
    cycle("t5_post");
    check_val("t5_lowest", obs_ready, 3'b010);

    // Saturation of the 4-bit counter
    do_reset("t6rst");
    req_valid = 3'b111;
    for (int i = 0; i < 20; i++) cycle("t6");
    check_val("t6_sat4", conflict_cnt4, 4'd15);
    check_val("t6_cnt16", conflict_cnt, 16'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
